// File: rtl/nonce_result_bank_pkg.sv
// rtl/nonce_result_bank_pkg.sv - shared sizes, digest bank types and FSM states for the nonce result bank
package nonce_result_bank_pkg;

    localparam int NUM_NONCES = 16;
    localparam int NUM_WORDS  = 8;
    localparam int WORD_W     = 32;
    localparam int LANE_W     = $clog2(NUM_NONCES);
    localparam int WIDX_W     = $clog2(NUM_WORDS);

    typedef logic [WORD_W-1:0]                 word_t;
    typedef word_t       [NUM_WORDS-1:0]       hash_words_t;
    typedef hash_words_t [NUM_NONCES-1:0]      lane_bank_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } bank_state_t;

endpackage

// File: rtl/nonce_result_bank_if.sv
// rtl/nonce_result_bank_if.sv - control, capture, stream and summary signals of the nonce result bank
// Ports (slave = bank side):
//   in : start, lane_wr_en, lane_hash, target, out_ready
//   out: busy, out_valid, out_lane, out_word, out_data, out_hit, out_last,
//        done, any_hit, hit_count, first_hit_lane
interface nonce_result_bank_if;
    import nonce_result_bank_pkg::*;

    logic                  start;
    logic [NUM_NONCES-1:0] lane_wr_en;
    lane_bank_t            lane_hash;
    word_t                 target;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANE_W-1:0]     out_lane;
    logic [WIDX_W-1:0]     out_word;
    word_t                 out_data;
    logic                  out_hit;
    logic                  out_last;
    logic                  done;
    logic                  any_hit;
    logic [LANE_W:0]       hit_count;
    logic [LANE_W-1:0]     first_hit_lane;

    modport slave (
        input  start, lane_wr_en, lane_hash, target, out_ready,
        output busy, out_valid, out_lane, out_word, out_data, out_hit, out_last,
               done, any_hit, hit_count, first_hit_lane
    );

    modport master (
        output start, lane_wr_en, lane_hash, target, out_ready,
        input  busy, out_valid, out_lane, out_word, out_data, out_hit, out_last,
               done, any_hit, hit_count, first_hit_lane
    );

endinterface

// File: rtl/nonce_result_bank_lane_word_serializer.sv
// rtl/nonce_result_bank_lane_word_serializer.sv - lane-major/word-minor beat counter for the digest stream
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_clear           : return counters to (lane 0, word 0)
//   i_advance         : beat accepted, step to the next (lane, word)
//   o_lane, o_word    : current beat position
//   o_last            : current beat is (N_LANES-1, N_WORDS-1)
module lane_word_serializer #(
    parameter int N_LANES = 16,
    parameter int N_WORDS = 8,
    parameter int L_W     = $clog2(N_LANES),
    parameter int W_W     = $clog2(N_WORDS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [L_W-1:0] o_lane,
    output logic [W_W-1:0] o_word,
    output logic           o_last
);

    localparam logic [L_W-1:0] LAST_LANE = L_W'(N_LANES - 1);
    localparam logic [W_W-1:0] LAST_WORD = W_W'(N_WORDS - 1);

    logic [L_W-1:0] r_lane;
    logic [W_W-1:0] r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_advance) begin
            if (r_word == LAST_WORD) begin
                r_word <= '0;
                // lane count is a power of two, so the final beat wraps back to lane 0
                r_lane <= r_lane + 1'b1;
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    assign o_lane = r_lane;
    assign o_word = r_word;
    assign o_last = (r_lane == LAST_LANE) && (r_word == LAST_WORD);

endmodule

// File: rtl/nonce_result_bank.sv
// rtl/nonce_result_bank.sv - captures per-lane SHA-256 digests, streams them out and summarises target hits
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : nonce_result_bank_if.slave (start/capture inputs, stream handshake, summary outputs)
module nonce_result_bank
    import nonce_result_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    nonce_result_bank_if.slave   bus
);

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

    bank_state_t           r_state;
    logic [NUM_NONCES-1:0] r_mask;
    lane_bank_t            r_bank;
    word_t                 r_target;
    logic                  r_busy;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_any_hit;
    logic [LANE_W:0]       r_hit_count;
    logic [LANE_W-1:0]     r_first_hit;

    logic                  w_accept_start;
    logic                  w_hs;
    logic [LANE_W-1:0]     w_lane;
    logic [WIDX_W-1:0]     w_word;
    logic                  w_last;
    logic                  w_hit;
    logic [NUM_NONCES-1:0] w_new_wr;
    logic [NUM_NONCES-1:0] w_next_mask;

    assign w_accept_start = (r_state == IDLE) && bus.start;
    assign w_hs           = r_valid && bus.out_ready;
    // only lanes not yet captured may write: first write wins
    assign w_new_wr       = bus.lane_wr_en & ~r_mask;
    assign w_next_mask    = r_mask | bus.lane_wr_en;
    assign w_hit          = r_bank[w_lane][0] < r_target;

    lane_word_serializer #(
        .N_LANES (NUM_NONCES),
        .N_WORDS (NUM_WORDS)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept_start),
        .i_advance (w_hs),
        .o_lane    (w_lane),
        .o_word    (w_word),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_bank      <= '0;
            r_target    <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_any_hit   <= 1'b0;
            r_hit_count <= '0;
            r_first_hit <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mask      <= '0;
                        r_any_hit   <= 1'b0;
                        r_hit_count <= '0;
                        r_first_hit <= '0;
                        r_target    <= bus.target;
                        r_busy      <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < NUM_NONCES; i++) begin
                        if (w_new_wr[i]) begin
                            r_bank[i] <= bus.lane_hash[i];
                        end
                    end
                    r_mask <= w_next_mask;
                    if (&w_next_mask) begin
                        r_valid <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        // a lane is tallied once, on its final word
                        if ((w_word == LAST_WORD) && w_hit) begin
                            r_hit_count <= r_hit_count + 1'b1;
                            if (!r_any_hit) begin
                                r_any_hit   <= 1'b1;
                                r_first_hit <= w_lane;
                            end
                        end
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // stream fields are forced to zero outside STREAM so idle/reset outputs read as 0
    assign bus.busy           = r_busy;
    assign bus.out_valid      = r_valid;
    assign bus.out_lane       = r_valid ? w_lane : '0;
    assign bus.out_word       = r_valid ? w_word : '0;
    assign bus.out_data       = r_valid ? r_bank[w_lane][w_word] : '0;
    assign bus.out_hit        = r_valid && w_hit;
    assign bus.out_last       = r_valid && w_last;
    assign bus.done           = r_done;
    assign bus.any_hit        = r_any_hit;
    assign bus.hit_count      = r_hit_count;
    assign bus.first_hit_lane = r_first_hit;

endmodule

// File: tb/tb_nonce_result_bank.sv
// tb/tb_nonce_result_bank.sv - scoreboard bench for nonce_result_bank with a lane/word reference model
module tb_nonce_result_bank;
    import nonce_result_bank_pkg::*;

    typedef struct {
        int    lane;
        int    word;
        word_t data;
        bit    hit;
        bit    last;
    } beat_t;

    typedef struct {
        bit any;
        int cnt;
        int first;
    } summ_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nonce_result_bank_if bus ();

    nonce_result_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t       exp_q[$];
    summ_t       sum_q[$];
    int          checks     = 0;
    int          errors     = 0;
    int          beats_seen = 0;
    int          dones_seen = 0;
    int          ready_mode = 0;
    hash_words_t model_cap[NUM_NONCES];
    bit          model_got[NUM_NONCES];
    bit          model_pushed;
    word_t       model_target;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference: every lane's first captured digest, streamed lane by lane, word by word
    function automatic void model_expect();
        summ_t s;
        s.any = 0; s.cnt = 0; s.first = 0;
        for (int l = 0; l < NUM_NONCES; l++) begin
            bit h;
            h = model_cap[l][0] < model_target;
            for (int w = 0; w < NUM_WORDS; w++) begin
                beat_t b;
                b.lane = l; b.word = w; b.data = model_cap[l][w]; b.hit = h;
                b.last = (l == NUM_NONCES - 1) && (w == NUM_WORDS - 1);
                exp_q.push_back(b);
            end
            if (h) begin
                if (!s.any) s.first = l;
                s.any = 1;
                s.cnt++;
            end
        end
        sum_q.push_back(s);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic lane_bank_t rand_bank();
        lane_bank_t h;
        for (int i = 0; i < NUM_NONCES; i++)
            for (int k = 0; k < NUM_WORDS; k++)
                h[i][k] = $urandom;
        return h;
    endfunction

    task automatic do_start(input word_t tgt);
        bus.start  = 1'b1;
        bus.target = tgt;
        model_target = tgt;
        model_pushed = 0;
        for (int i = 0; i < NUM_NONCES; i++) model_got[i] = 0;
        cyc();
        bus.start  = 1'b0;
        bus.target = $urandom;
    endtask

    task automatic write_lanes(input logic [NUM_NONCES-1:0] en, input lane_bank_t h);
        bit all;
        chk("valid_before_full", bus.out_valid, 0);
        bus.lane_wr_en = en;
        bus.lane_hash  = h;
        all = 1;
        for (int i = 0; i < NUM_NONCES; i++) begin
            if (en[i] && !model_got[i]) begin
                model_cap[i] = h[i];
                model_got[i] = 1;
            end
            if (!model_got[i]) all = 0;
        end
        if (all && !model_pushed) begin
            model_pushed = 1;
            model_expect();
        end
        cyc();
        bus.lane_wr_en = '0;
        bus.lane_hash  = rand_bank();
        if (all) chk("valid_after_full", bus.out_valid, 1);
    endtask

    task automatic wait_done();
        int prev, n;
        prev = dones_seen;
        n = 0;
        while (dones_seen == prev && n < 3000) begin
            cyc();
            n++;
        end
        chk("done_seen", dones_seen != prev, 1);
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int n);
        int base, c;
        base = beats_seen;
        c = 0;
        while (beats_seen - base < n && c < 3000) begin
            cyc();
            c++;
        end
        chk("beats_reached", beats_seen - base >= n, 1);
    endtask

    task automatic check_zero(input string name);
        chk(name, {bus.busy, bus.out_valid, bus.out_lane, bus.out_word, bus.out_data, bus.out_hit,
                   bus.out_last, bus.done, bus.any_hit, bus.hit_count, bus.first_hit_lane}, 0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_zero("reset_outputs");
        #3 reset = 1'b0;
        exp_q.delete();
        sum_q.delete();
        cyc();
    endtask

    // out_ready policy: 0 always ready, 1 alternate, 2 random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops an expected beat on each handshake, checks stall stability and the done summary
    initial begin
        bit    prev_stall = 0;
        bit    prev_last_hs = 0;
        bit    cur_last_hs;
        logic [LANE_W+WIDX_W+WORD_W+1:0] saved = '0;
        logic [LANE_W+WIDX_W+WORD_W+1:0] cur;
        forever begin
            @(negedge clk);
            cur_last_hs = 0;
            if (reset) begin
                prev_stall   = 0;
                prev_last_hs = 0;
            end else begin
                cur = {bus.out_lane, bus.out_word, bus.out_data, bus.out_hit, bus.out_last};
                if (bus.out_valid) begin
                    if (prev_stall) chk("stall_stable", cur, saved);
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", 1, 0);
                        end else begin
                            beat_t e;
                            e = exp_q.pop_front();
                            chk("beat_lane", bus.out_lane, e.lane);
                            chk("beat_word", bus.out_word, e.word);
                            chk("beat_data", bus.out_data, e.data);
                            chk("beat_hit_last", {bus.out_hit, bus.out_last}, {e.hit, e.last});
                        end
                        beats_seen++;
                        cur_last_hs = bus.out_last;
                        prev_stall  = 0;
                    end else begin
                        prev_stall = 1;
                        saved      = cur;
                    end
                end else begin
                    prev_stall = 0;
                end
                if (bus.done) begin
                    chk("done_after_last", prev_last_hs, 1);
                    chk("done_valid_busy", {bus.out_valid, bus.busy}, 0);
                    if (sum_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        summ_t s;
                        s = sum_q.pop_front();
                        chk("sum_any_hit", bus.any_hit, s.any);
                        chk("sum_hit_count", bus.hit_count, s.cnt);
                        chk("sum_first_hit", bus.first_hit_lane, s.first);
                    end
                    dones_seen++;
                end
                prev_last_hs = cur_last_hs;
            end
        end
    end

    initial begin
        lane_bank_t h;
        int         base;
        bus.start      = 1'b0;
        bus.lane_wr_en = '0;
        bus.lane_hash  = '0;
        bus.target     = '0;

        // 1: reset, idle writes ignored, mid-cycle reset
        #2 reset = 1'b1;
        #1 check_zero("power_on_reset");
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.lane_wr_en = 16'($urandom);
            bus.lane_hash  = rand_bank();
            bus.target     = $urandom;
            cyc();
            chk("idle_not_busy", bus.busy, 0);
        end
        bus.lane_wr_en = '0;
        mid_reset();

        // 2: all lanes at once, fixed pattern, lanes 0-3 below target
        ready_mode = 0;
        do_start(32'h1000_0004);
        for (int i = 0; i < NUM_NONCES; i++)
            for (int k = 0; k < NUM_WORDS; k++)
                h[i][k] = (k == 0) ? 32'h1000_0000 + i : (i << 8) | k;
        write_lanes('1, h);
        wait_done();
        chk("t2_hit_count", bus.hit_count, 4);
        chk("t2_first_hit", bus.first_hit_lane, 0);
        chk("t2_any_hit", bus.any_hit, 1);

        // 3: staggered writes 15..0, lane 5 rewritten with a different value
        ready_mode = 2;
        do_start(32'h8000_0000);
        for (int l = NUM_NONCES - 1; l >= 0; l--) begin
            logic [NUM_NONCES-1:0] en;
            h  = rand_bank();
            en = '0;
            en[l] = 1'b1;
            if (l == 4) en[5] = 1'b1;
            write_lanes(en, h);
        end
        wait_done();

        // 4: alternating out_ready
        ready_mode = 1;
        do_start($urandom);
        write_lanes('1, rand_bank());
        base = beats_seen;
        wait_done();
        chk("t4_beat_total", beats_seen - base, NUM_NONCES * NUM_WORDS);

        // 5: target 0 gives no hits, then a single hit on lane 9
        ready_mode = 2;
        do_start(32'h0);
        write_lanes('1, rand_bank());
        wait_done();
        chk("t5_no_hit", {bus.any_hit, bus.hit_count, bus.first_hit_lane}, 0);
        h = rand_bank();
        for (int i = 0; i < NUM_NONCES; i++) h[i][0] = h[i][0] | 32'h1;
        h[9][0] = 32'h0;
        do_start(32'h1);
        write_lanes('1, h);
        wait_done();
        chk("t5_hit_count", bus.hit_count, 1);
        chk("t5_first_hit", bus.first_hit_lane, 9);
        cyc();
        chk("t5_summary_held", {bus.any_hit, bus.hit_count, bus.first_hit_lane}, {1'b1, 5'd1, 4'd9});

        // 6: start during STREAM is ignored; reset at beat 40; then a clean full run
        do_start(32'h4000_0000);
        write_lanes('1, rand_bank());
        wait_beats(20);
        bus.start  = 1'b1;
        bus.target = 32'hFFFF_FFFF;
        cyc();
        bus.start  = 1'b0;
        wait_done();

        ready_mode = 0;
        do_start($urandom);
        write_lanes('1, rand_bank());
        wait_beats(40);
        mid_reset();
        chk("post_reset_idle", {bus.busy, bus.out_valid}, 0);

        ready_mode = 2;
        do_start($urandom);
        write_lanes('1, rand_bank());
        base = beats_seen;
        wait_done();
        chk("t6_beat_total", beats_seen - base, NUM_NONCES * NUM_WORDS);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
